// File: rtl/wb_dst_ctrl.sv
// Write-back sequencer for the multicycle CPU: decodes the latched instruction fields, steers the
// register-file destination/data muxes, waits on memory for loads and pulses reg_write per destination.
module wb_dst_ctrl #(
  parameter logic [5:0] OP_RTYPE    = 6'h00,
  parameter logic [5:0] OP_JAL      = 6'h03,
  parameter logic [5:0] OP_LW       = 6'h23,
  parameter logic [5:0] OP_PUSH     = 6'h1E,
  parameter logic [5:0] OP_POP      = 6'h1F,
  parameter logic [5:0] OP_RSWB     = 6'h10,
  parameter int         MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic [2:0] regDSTmux,
  output logic [1:0] wb_src,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] DST_RT  = 3'b000;
  localparam logic [2:0] DST_RD  = 3'b001;
  localparam logic [2:0] DST_SP  = 3'b010;
  localparam logic [2:0] DST_RA  = 3'b011;
  localparam logic [2:0] DST_RS  = 3'b100;
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;
  localparam logic [1:0] SRC_SP  = 2'b11;

  typedef enum logic [2:0] {IDLE, DECODE, WAIT_MEM, WRITE, WRITE2, DONE} state_t;

  typedef struct packed {
    logic       legal;
    logic       wr;
    logic       mem;
    logic       pop;
    logic [2:0] dst;
    logic [1:0] src;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.legal = 1'b1;
        d.wr    = (fn != 6'h08);
        d.dst   = DST_RD;
        d.src   = (fn == 6'h09) ? SRC_PC4 : SRC_ALU;
      end
      OP_JAL:  begin d.legal = 1'b1; d.wr = 1'b1; d.dst = DST_RA; d.src = SRC_PC4; end
      OP_LW:   begin d.legal = 1'b1; d.wr = 1'b1; d.mem = 1'b1; d.dst = DST_RT; d.src = SRC_MEM; end
      OP_PUSH: begin d.legal = 1'b1; d.wr = 1'b1; d.dst = DST_SP; d.src = SRC_SP; end
      OP_POP: begin
        d.legal = 1'b1; d.wr = 1'b1; d.mem = 1'b1; d.pop = 1'b1;
        d.dst = DST_RT; d.src = SRC_MEM;
      end
      OP_RSWB: begin d.legal = 1'b1; d.wr = 1'b1; d.dst = DST_RS; d.src = SRC_ALU; end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0F: begin
        d.legal = 1'b1; d.wr = 1'b1; d.dst = DST_RT; d.src = SRC_ALU;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    op_q, op_d, fn_q, fn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dst_q, dst_d;
  logic [1:0]    src_q, src_d;
  logic          rw_q, rw_d, busy_q, busy_d, done_q, done_d;
  logic          ill_q, ill_d, merr_q, merr_d;
  dec_t          dec_in, dec_l;

  assign dec_in = decode(opcode, funct);
  assign dec_l  = decode(op_q, fn_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    src_d   = src_q;
    rw_d    = 1'b0;
    ill_d   = 1'b0;
    merr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = opcode;
          fn_d    = funct;
          state_d = DECODE;
          // Selects are loaded as DECODE begins so they lead reg_write by a full cycle.
          if (dec_in.legal && dec_in.wr) begin
            dst_d = dec_in.dst;
            src_d = dec_in.src;
          end
        end
      end
      DECODE: begin
        if (!dec_l.legal) begin
          state_d = DONE;
          ill_d   = 1'b1;
        end else if (!dec_l.wr) begin
          state_d = DONE;
        end else if (dec_l.mem) begin
          state_d = WAIT_MEM;
          cnt_d   = '0;
        end else begin
          state_d = WRITE;
          rw_d    = 1'b1;
        end
      end
      WAIT_MEM: begin
        if (mem_ready) begin
          state_d = WRITE;
          rw_d    = 1'b1;
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = DONE;
          merr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (dec_l.pop) begin
          state_d = WRITE2;
          rw_d    = 1'b1;
          dst_d   = DST_SP;
          src_d   = SRC_SP;
        end else begin
          state_d = DONE;
        end
      end
      WRITE2:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      dst_q   <= DST_RT;
      src_q   <= SRC_ALU;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      merr_q  <= merr_d;
    end
  end

  assign regDSTmux = dst_q;
  assign wb_src    = src_q;
  assign reg_write = rw_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign illegal   = ill_q;
  assign mem_err   = merr_q;

endmodule

// File: tb/tb_wb_dst_ctrl.sv
// Directed bench for wb_dst_ctrl: each task drives one scenario and checks outputs inline.
module tb_wb_dst_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, mem_ready;
  logic [5:0] opcode, funct;
  logic [2:0] regDSTmux;
  logic [1:0] wb_src;
  logic       reg_write, busy, done, illegal, mem_err;

  int passed = 0;
  int total  = 0;

  wb_dst_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .regDSTmux(regDSTmux), .wb_src(wb_src), .reg_write(reg_write),
    .busy(busy), .done(done), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start sampled at edge N; returns just after edge N (k = 0, DECODE).
  task automatic issue(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Watches cycles k = 0.. after issue until done; k counts edges after N.
  task automatic observe(input int max_k, input int mem_at, input int start_at,
                         output int wr_cnt, output int wr_k, output int done_k,
                         output logic [2:0] d1, output logic [1:0] s1,
                         output logic [2:0] d2, output logic [1:0] s2,
                         output logic ill, output logic merr);
    wr_cnt = 0; wr_k = -1; done_k = -1;
    d1 = 3'b111; s1 = 2'b00; d2 = 3'b111; s2 = 2'b00; ill = 1'b0; merr = 1'b0;
    for (int k = 0; k < max_k; k++) begin
      if (reg_write) begin
        if (wr_cnt == 0) begin wr_k = k; d1 = regDSTmux; s1 = wb_src; end
        d2 = regDSTmux; s2 = wb_src;
        wr_cnt++;
      end
      if (done) begin
        done_k = k; ill = illegal; merr = mem_err;
        break;
      end
      mem_ready = (k == mem_at);
      start     = (k == start_at);
      tick();
    end
    mem_ready = 1'b0;
    start     = 1'b0;
    $display("op %02h fn %02h: writes=%0d first_wr_k=%0d done_k=%0d ill=%0b merr=%0b",
             opcode, funct, wr_cnt, wr_k, done_k, ill, merr);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++; if (regDSTmux !== 3'b000) $display("FAIL reset_dst got %b exp 000", regDSTmux); else passed++;
    total++; if (wb_src !== 2'b00) $display("FAIL reset_src got %b exp 00", wb_src); else passed++;
    total++; if ({reg_write, busy, done, illegal, mem_err} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000", {reg_write, busy, done, illegal, mem_err});
    else passed++;
  endtask

  task automatic test_alu();
    issue(6'h00, 6'h20);
    total++; if ({busy, reg_write} !== 2'b10) $display("FAIL add_k0 busy/rw got %b exp 10", {busy, reg_write}); else passed++;
    total++; if ({regDSTmux, wb_src} !== 5'b001_00) $display("FAIL add_k0_mux got %b exp 00100", {regDSTmux, wb_src}); else passed++;
    tick();
    total++; if ({busy, reg_write, done} !== 3'b110) $display("FAIL add_k1 got %b exp 110", {busy, reg_write, done}); else passed++;
    total++; if ({regDSTmux, wb_src} !== 5'b001_00) $display("FAIL add_k1_mux got %b exp 00100", {regDSTmux, wb_src}); else passed++;
    tick();
    total++; if ({busy, reg_write, done} !== 3'b101) $display("FAIL add_k2 got %b exp 101", {busy, reg_write, done}); else passed++;
    tick();
    total++; if ({busy, reg_write, done} !== 3'b000) $display("FAIL add_k3 got %b exp 000", {busy, reg_write, done}); else passed++;
    $display("op 00 fn 20: add sequence checked");
  endtask

  task automatic test_decode_table();
    logic [5:0] ops [6] = '{6'h03, 6'h00, 6'h1E, 6'h10, 6'h0A, 6'h08};
    logic [5:0] fns [6] = '{6'h00, 6'h09, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [4:0] exp [6] = '{5'b011_10, 5'b001_10, 5'b010_11, 5'b100_00, 5'b000_00, 5'b000_00};
    int wc, wk, dk; logic [2:0] d1, d2; logic [1:0] s1, s2; logic il, me;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], fns[i]);
      observe(10, -1, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
      total++; if (wc !== 1) $display("FAIL dec%0d_writes got %0d exp 1", i, wc); else passed++;
      total++; if ({d1, s1} !== exp[i]) $display("FAIL dec%0d_mux got %b exp %b", i, {d1, s1}, exp[i]); else passed++;
      total++; if (wk !== 1 || dk !== 2) $display("FAIL dec%0d_lat got wr %0d done %0d exp 1 2", i, wk, dk); else passed++;
      tick();
    end
  endtask

  task automatic test_jr();
    int wc, wk, dk; logic [2:0] d1, d2; logic [1:0] s1, s2; logic il, me;
    issue(6'h00, 6'h08);
    observe(10, -1, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
    total++; if (wc !== 0) $display("FAIL jr_writes got %0d exp 0", wc); else passed++;
    total++; if (dk !== 1 || il !== 1'b0) $display("FAIL jr_done got k %0d ill %0b exp 1 0", dk, il); else passed++;
    tick();
  endtask

  task automatic test_load();
    int wc, wk, dk; logic [2:0] d1, d2; logic [1:0] s1, s2; logic il, me;
    issue(6'h23, 6'h00);
    observe(20, 3, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
    total++; if (wc !== 1 || wk !== 4) $display("FAIL lw_write got n %0d k %0d exp 1 4", wc, wk); else passed++;
    total++; if ({d1, s1} !== 5'b000_01) $display("FAIL lw_mux got %b exp 00001", {d1, s1}); else passed++;
    total++; if (dk !== 5 || me !== 1'b0) $display("FAIL lw_done got k %0d merr %0b exp 5 0", dk, me); else passed++;
    tick();
    issue(6'h23, 6'h00);
    observe(20, -1, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
    total++; if (wc !== 0) $display("FAIL lw_to_writes got %0d exp 0", wc); else passed++;
    total++; if (dk !== 9 || me !== 1'b1) $display("FAIL lw_to_done got k %0d merr %0b exp 9 1", dk, me); else passed++;
    tick();
    // mem_ready on the 8th (last) WAIT_MEM cycle still completes the load
    issue(6'h23, 6'h00);
    observe(20, 8, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
    total++; if (wc !== 1 || wk !== 9) $display("FAIL lw_last_write got n %0d k %0d exp 1 9", wc, wk); else passed++;
    total++; if (dk !== 10 || me !== 1'b0) $display("FAIL lw_last_done got k %0d merr %0b exp 10 0", dk, me); else passed++;
    tick();
  endtask

  task automatic test_pop();
    int wc, wk, dk; logic [2:0] d1, d2; logic [1:0] s1, s2; logic il, me;
    issue(6'h1F, 6'h00);
    observe(20, 1, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
    total++; if (wc !== 2 || wk !== 2) $display("FAIL pop_writes got n %0d k %0d exp 2 2", wc, wk); else passed++;
    total++; if ({d1, s1} !== 5'b000_01) $display("FAIL pop_mux1 got %b exp 00001", {d1, s1}); else passed++;
    total++; if ({d2, s2} !== 5'b010_11) $display("FAIL pop_mux2 got %b exp 01011", {d2, s2}); else passed++;
    total++; if (dk !== 4) $display("FAIL pop_done got k %0d exp 4", dk); else passed++;
    tick();
  endtask

  task automatic test_illegal();
    int wc, wk, dk; logic [2:0] d1, d2; logic [1:0] s1, s2; logic il, me;
    issue(6'h3B, 6'h00);
    observe(10, -1, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
    total++; if (wc !== 0 || dk !== 1 || il !== 1'b1)
      $display("FAIL illegal got wr %0d k %0d ill %0b exp 0 1 1", wc, dk, il);
    else passed++;
    total++; if ({regDSTmux, wb_src} !== 5'b010_11) $display("FAIL illegal_hold got %b exp 01011", {regDSTmux, wb_src}); else passed++;
    tick();
  endtask

  task automatic test_start_while_busy();
    int wc, wk, dk; logic [2:0] d1, d2; logic [1:0] s1, s2; logic il, me;
    issue(6'h23, 6'h00);
    opcode = 6'h00; funct = 6'h20;
    observe(20, 3, 1, wc, wk, dk, d1, s1, d2, s2, il, me);
    total++; if (wc !== 1 || {d1, s1} !== 5'b000_01) $display("FAIL busy_start got n %0d mux %b exp 1 00001", wc, {d1, s1}); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL busy_start_idle got %b exp 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int wc, wk, dk; logic [2:0] d1, d2; logic [1:0] s1, s2; logic il, me;
    issue(6'h00, 6'h20);
    observe(10, -1, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
    tick();
    issue(6'h03, 6'h00);
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy %b exp 1", busy); else passed++;
    observe(10, -1, -1, wc, wk, dk, d1, s1, d2, s2, il, me);
    total++; if (wc !== 1 || dk !== 2 || {d1, s1} !== 5'b011_10)
      $display("FAIL b2b_jal got n %0d k %0d mux %b exp 1 2 01110", wc, dk, {d1, s1});
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    issue(6'h23, 6'h00);
    tick(); tick();
    reset = 1'b1; mem_ready = 1'b1;
    tick();
    total++; if ({busy, reg_write, done} !== 3'b000) $display("FAIL rst_mid got %b exp 000", {busy, reg_write, done}); else passed++;
    reset = 1'b0;
    wr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (reg_write || done) wr_seen++;
    end
    mem_ready = 1'b0;
    total++; if (wr_seen !== 0) $display("FAIL rst_mid_write got %0d exp 0", wr_seen); else passed++;
    $display("reset during WAIT_MEM: checked");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_decode_table();
    test_jr();
    test_load();
    test_pop();
    test_illegal();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
